// File: rtl/uart_bit_receiver.sv
//-----------------------------------------------------------------------------
// uart_bit_receiver
//
// Receives 8N1 UART frames (LSB first on the wire). Each good byte is
// re-emitted one bit per clock, MSB first, as a serial bit stream for a
// downstream parser.
//
// Parameters
//   CLKS_PER_BIT      clock cycles per UART bit (16..65535), default 868
//
// Ports
//   clk               system clock, rising-edge active
//   rst               asynchronous active-low reset
//   rx                asynchronous UART line, idle high
//   output_bit        current emitted data bit (holds its value between bytes)
//   is_new_output_bit one-cycle strobe qualifying output_bit
//   frame_error       one-cycle pulse when a stop bit is sampled low
//   busy              high whenever the receive FSM is outside IDLE
//-----------------------------------------------------------------------------
module uart_bit_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic output_bit,
  output logic is_new_output_bit,
  output logic frame_error,
  output logic busy
);

  // Timer compare points. The timer is cleared on every state change and
  // after each data sample, so a value of N-1 means N cycles have elapsed.
  localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rxState_t;

  rxState_t    r_state;
  rxState_t    w_nextState;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_rxPrev;
  logic        w_rxS;
  logic        w_fallEdge;

  logic [15:0] r_timer;
  logic [2:0]  r_bitCnt;
  logic [7:0]  r_shift;

  logic        w_timerClr;
  logic        w_sampleData;
  logic        w_loadEmit;
  logic        w_stopBad;

  logic [7:0]  r_emitBuf;
  logic [3:0]  r_emitCnt;
  logic        r_emitActive;
  logic        r_outBit;
  logic        r_frameErr;

  // Two-flop synchronizer; both flops reset high so reset never looks like
  // a start bit. r_rxPrev is an extra stage used only for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= rx;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  assign w_rxS      = r_sync2;
  assign w_fallEdge = r_rxPrev & ~w_rxS;

  // Receive FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_nextState  = r_state;
    w_sampleData = 1'b0;
    w_loadEmit   = 1'b0;
    w_stopBad    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fallEdge) begin
          w_nextState = START;
        end
      end
      START: begin
        // Mid-start-bit check: a line that is already high again was a glitch.
        if (r_timer == LP_HALF) begin
          if (!w_rxS) begin
            w_nextState = DATA;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      DATA: begin
        if (r_timer == LP_FULL) begin
          w_sampleData = 1'b1;
          if (r_bitCnt == 3'd7) begin
            w_nextState = STOP;
          end
        end
      end
      STOP: begin
        if (r_timer == LP_FULL) begin
          if (w_rxS) begin
            w_loadEmit  = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_stopBad   = 1'b1;
            w_nextState = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_rxS) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Restart the timer both on state changes and after every data sample so
  // each data bit is measured from the previous sample point.
  assign w_timerClr = (w_nextState != r_state) || w_sampleData;

  // Bit timer, data bit counter and receive shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer  <= 16'd0;
      r_bitCnt <= 3'd0;
      r_shift  <= 8'd0;
    end else begin
      if (w_timerClr) begin
        r_timer <= 16'd0;
      end else if ((r_state == START) || (r_state == DATA) || (r_state == STOP)) begin
        r_timer <= r_timer + 16'd1;
      end else begin
        r_timer <= 16'd0;
      end

      if (r_state == START) begin
        r_bitCnt <= 3'd0;
      end else if (w_sampleData) begin
        r_bitCnt <= r_bitCnt + 3'd1;
      end

      // LSB arrives first, so new bits enter at the top and move down.
      if (w_sampleData) begin
        r_shift <= {w_rxS, r_shift[7:1]};
      end
    end
  end

  // Emitter. On a good stop bit the first (MSB) bit is presented right away
  // and the rest of the byte is parked in r_emitBuf, which shifts left so
  // the next bit to emit is always at bit 7. It runs independently of the
  // receive FSM; a new load can never land on an active emission because a
  // frame is far longer than eight cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_emitBuf    <= 8'd0;
      r_emitCnt    <= 4'd0;
      r_emitActive <= 1'b0;
      r_outBit     <= 1'b0;
    end else if (w_loadEmit) begin
      r_outBit     <= r_shift[7];
      r_emitBuf    <= {r_shift[6:0], 1'b0};
      r_emitCnt    <= 4'd1;
      r_emitActive <= 1'b1;
    end else if (r_emitActive) begin
      if (r_emitCnt == 4'd8) begin
        r_emitActive <= 1'b0;
      end else begin
        r_outBit  <= r_emitBuf[7];
        r_emitBuf <= {r_emitBuf[6:0], 1'b0};
        r_emitCnt <= r_emitCnt + 4'd1;
      end
    end
  end

  // Frame error is registered so it appears the cycle after the stop sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frameErr <= 1'b0;
    end else begin
      r_frameErr <= w_stopBad;
    end
  end

  assign output_bit        = r_outBit;
  assign is_new_output_bit = r_emitActive;
  assign frame_error       = r_frameErr;
  assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_uart_bit_receiver.sv
//-----------------------------------------------------------------------------
// tb_uart_bit_receiver
//
// Directed bench for uart_bit_receiver with CLKS_PER_BIT = 16. A passive
// monitor records every strobed output bit and every frame_error cycle;
// each scenario task drives rx and compares against hand-computed values.
//-----------------------------------------------------------------------------
module tb_uart_bit_receiver;

  localparam int CPB = 16;

  logic clk;
  logic rst;
  logic rx;
  logic output_bit;
  logic is_new_output_bit;
  logic frame_error;
  logic busy;

  int   vectors;
  int   miscompares;
  int   cycleCnt;
  int   feCount;
  logic bitQ[$];
  int   cycQ[$];

  uart_bit_receiver #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx               (rx),
    .output_bit       (output_bit),
    .is_new_output_bit(is_new_output_bit),
    .frame_error      (frame_error),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Passive monitor, sampling on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (is_new_output_bit === 1'b1) begin
      bitQ.push_back(output_bit);
      cycQ.push_back(cycleCnt);
    end
    if (frame_error === 1'b1) begin
      feCount = feCount + 1;
    end
  end

  // Overall time limit so a stuck run still ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearMonitor();
    bitQ.delete();
    cycQ.delete();
    feCount = 0;
  endtask

  function automatic logic [31:0] packBits();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < bitQ.size(); i++) begin
      v = {v[30:0], bitQ[i]};
    end
    return v;
  endfunction

  task automatic driveBit(input logic val);
    rx = val;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopVal);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) begin
      driveBit(data[i]);
    end
    driveBit(stopVal);
  endtask

  task automatic idleGap(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (output_bit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_output_bit: got %b expected 0", output_bit);
    end
    vectors++;
    if (is_new_output_bit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_strobe: got %b expected 0", is_new_output_bit);
    end
    vectors++;
    if (frame_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_frame_error: got %b expected 0", frame_error);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    rst = 1'b1;
    idleGap(10);
  endtask

  task automatic test_single_byte();
    int c0;
    clearMonitor();
    c0 = cycleCnt;
    sendFrame(8'hBA, 1'b1);
    idleGap(30);
    vectors++;
    if (bitQ.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL single_count: got %0d expected 8", bitQ.size());
    end
    vectors++;
    if (packBits() !== 32'h0000_00BA) begin
      miscompares++;
      $display("[TB] FAIL single_value: got %h expected 000000ba", packBits());
    end
    vectors++;
    if ((cycQ.size() != 8) || (cycQ[7] - cycQ[0] != 7)) begin
      miscompares++;
      $display("[TB] FAIL single_consecutive: got %0d strobes not in consecutive cycles expected 8 consecutive", cycQ.size());
    end
    // The stop bit is driven from cycle c0+144 to c0+160; emission starts
    // once it has been sampled, so the first strobe must land inside it.
    vectors++;
    if ((cycQ.size() == 0) || (cycQ[0] < c0 + 144) || (cycQ[0] > c0 + 160)) begin
      miscompares++;
      $display("[TB] FAIL single_latency: got first strobe at offset %0d expected within 144..160",
               (cycQ.size() == 0) ? -1 : cycQ[0] - c0);
    end
    vectors++;
    if (feCount != 0) begin
      miscompares++;
      $display("[TB] FAIL single_frame_error: got %0d expected 0", feCount);
    end
    vectors++;
    if (output_bit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_hold: got %b expected 0", output_bit);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_busy_idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    clearMonitor();
    sendFrame(8'hBA, 1'b1);
    sendFrame(8'hCD, 1'b1);
    sendFrame(8'h12, 1'b1);
    sendFrame(8'h34, 1'b1);
    idleGap(30);
    vectors++;
    if (bitQ.size() != 32) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d expected 32", bitQ.size());
    end
    vectors++;
    if (packBits() !== 32'hBACD_1234) begin
      miscompares++;
      $display("[TB] FAIL b2b_value: got %h expected bacd1234", packBits());
    end
    vectors++;
    if (feCount != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_frame_error: got %0d expected 0", feCount);
    end
  endtask

  task automatic test_glitch();
    logic cleared;
    clearMonitor();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL glitch_busy_set: got %b expected 1", busy);
    end
    @(negedge clk);
    rx = 1'b1;
    cleared = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b0) cleared = 1'b1;
    end
    vectors++;
    if (!cleared) begin
      miscompares++;
      $display("[TB] FAIL glitch_busy_clear: got busy=%b after 10 cycles expected 0", busy);
    end
    idleGap(30);
    vectors++;
    if (bitQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_strobes: got %0d expected 0", bitQ.size());
    end
    vectors++;
    if (feCount != 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_frame_error: got %0d expected 0", feCount);
    end
  endtask

  task automatic test_frame_error();
    logic cleared;
    clearMonitor();
    sendFrame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    vectors++;
    if (feCount != 1) begin
      miscompares++;
      $display("[TB] FAIL ferr_count: got %0d expected 1", feCount);
    end
    vectors++;
    if (bitQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL ferr_strobes: got %0d expected 0", bitQ.size());
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ferr_busy_held: got %b expected 1", busy);
    end
    rx = 1'b1;
    cleared = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b0) cleared = 1'b1;
    end
    vectors++;
    if (!cleared) begin
      miscompares++;
      $display("[TB] FAIL ferr_busy_release: got busy=%b expected 0", busy);
    end
    idleGap(20);
  endtask

  task automatic test_stuck_low();
    logic cleared;
    clearMonitor();
    rx = 1'b0;
    repeat (25 * CPB) @(negedge clk);
    vectors++;
    if (feCount != 1) begin
      miscompares++;
      $display("[TB] FAIL stuck_frame_error: got %0d expected 1", feCount);
    end
    vectors++;
    if (bitQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stuck_strobes: got %0d expected 0", bitQ.size());
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stuck_busy: got %b expected 1", busy);
    end
    rx = 1'b1;
    cleared = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b0) cleared = 1'b1;
    end
    vectors++;
    if (!cleared) begin
      miscompares++;
      $display("[TB] FAIL stuck_release: got busy=%b expected 0", busy);
    end
    idleGap(20);
  endtask

  task automatic test_reset_mid_frame();
    clearMonitor();
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    driveBit(1'b1);
    repeat (CPB / 2) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midframe_busy_before: got %b expected 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midframe_busy_async: got %b expected 0", busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idleGap(20);
    sendFrame(8'h0F, 1'b1);
    idleGap(30);
    vectors++;
    if (bitQ.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL midframe_count: got %0d expected 8", bitQ.size());
    end
    vectors++;
    if (packBits() !== 32'h0000_000F) begin
      miscompares++;
      $display("[TB] FAIL midframe_value: got %h expected 0000000f", packBits());
    end
    vectors++;
    if (feCount != 0) begin
      miscompares++;
      $display("[TB] FAIL midframe_frame_error: got %0d expected 0", feCount);
    end
    vectors++;
    if (output_bit !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midframe_hold: got %b expected 1", output_bit);
    end
  endtask

  task automatic test_reset_mid_emission();
    logic found;
    clearMonitor();
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'hA5;
      driveBit(d[i]);
    end
    rx = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        @(negedge clk);
        if (is_new_output_bit === 1'b1) found = 1'b1;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL emit_start: got no strobe within 40 cycles expected a strobe");
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (is_new_output_bit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL emit_abort_strobe: got %b expected 0", is_new_output_bit);
    end
    vectors++;
    if (output_bit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL emit_abort_bit: got %b expected 0", output_bit);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idleGap(30);
    vectors++;
    if (bitQ.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL emit_abort_count: got %0d expected 3", bitQ.size());
    end
    vectors++;
    if (packBits() !== 32'h0000_0005) begin
      miscompares++;
      $display("[TB] FAIL emit_abort_value: got %h expected 00000005", packBits());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycleCnt    = 0;
    feCount     = 0;
    rst         = 1'b0;
    rx          = 1'b1;
    $display("[TB] starting uart_bit_receiver bench, CLKS_PER_BIT=%0d", CPB);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_stuck_low();
    test_reset_mid_emission();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
